// File: rtl/conv5x5_mac.sv
// 5x5 fixed-point convolution over a streaming window, 4-stage MAC pipeline after window qualification.
// Result valid the cycle after the 4th edge past the qualifying pixel; free-running, no backpressure.
module conv5x5_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int COORD_W    = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  shift_in,
   input  logic [DATA_WIDTH-1:0] w1,
   input  logic [DATA_WIDTH-1:0] w2,
   input  logic [DATA_WIDTH-1:0] w3,
   input  logic [DATA_WIDTH-1:0] w4,
   input  logic [DATA_WIDTH-1:0] w5,
   input  logic [DATA_WIDTH-1:0] w6,
   input  logic [DATA_WIDTH-1:0] w7,
   input  logic [DATA_WIDTH-1:0] w8,
   input  logic [DATA_WIDTH-1:0] w9,
   input  logic [DATA_WIDTH-1:0] w10,
   input  logic [DATA_WIDTH-1:0] w11,
   input  logic [DATA_WIDTH-1:0] w12,
   input  logic [DATA_WIDTH-1:0] w13,
   input  logic [DATA_WIDTH-1:0] w14,
   input  logic [DATA_WIDTH-1:0] w15,
   input  logic [DATA_WIDTH-1:0] w16,
   input  logic [DATA_WIDTH-1:0] w17,
   input  logic [DATA_WIDTH-1:0] w18,
   input  logic [DATA_WIDTH-1:0] w19,
   input  logic [DATA_WIDTH-1:0] w20,
   input  logic [DATA_WIDTH-1:0] w21,
   input  logic [DATA_WIDTH-1:0] w22,
   input  logic [DATA_WIDTH-1:0] w23,
   input  logic [DATA_WIDTH-1:0] w24,
   input  logic [DATA_WIDTH-1:0] w25,
   input  logic                  wt_we,
   input  logic [4:0]            wt_addr,
   input  logic [DATA_WIDTH-1:0] wt_data,
   output logic [DATA_WIDTH-1:0] conv_out,
   output logic                  out_valid,
   output logic [COORD_W-1:0]    out_row,
   output logic [COORD_W-1:0]    out_col,
   output logic                  out_last
);

   localparam int P_W   = 2 * DATA_WIDTH;
   localparam int PS_W  = P_W + 3;
   localparam int ACC_W = P_W + 6;

   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
   localparam logic [COORD_W-1:0] EDGE     = COORD_W'(4);
   localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

   typedef struct packed {
      logic               vld;
      logic               last;
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
   } meta_t;

   logic signed [DATA_WIDTH-1:0] tap  [25];
   logic signed [DATA_WIDTH-1:0] kern [25];
   logic signed [DATA_WIDTH-1:0] bias;

   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;

   meta_t q_meta, s1_meta, s2_meta, s3_meta;

   logic signed [P_W-1:0]   prod   [25];
   logic signed [PS_W-1:0]  psum_c [5];
   logic signed [PS_W-1:0]  psum   [5];
   logic signed [ACC_W-1:0] total_c;
   logic signed [ACC_W-1:0] total;
   logic signed [ACC_W-1:0] rnd;
   logic signed [ACC_W-1:0] shd;
   logic [ACC_W-DATA_WIDTH:0] hi;
   logic [DATA_WIDTH-1:0]   sat;

   assign tap[0]  = w1;
   assign tap[1]  = w2;
   assign tap[2]  = w3;
   assign tap[3]  = w4;
   assign tap[4]  = w5;
   assign tap[5]  = w6;
   assign tap[6]  = w7;
   assign tap[7]  = w8;
   assign tap[8]  = w9;
   assign tap[9]  = w10;
   assign tap[10] = w11;
   assign tap[11] = w12;
   assign tap[12] = w13;
   assign tap[13] = w14;
   assign tap[14] = w15;
   assign tap[15] = w16;
   assign tap[16] = w17;
   assign tap[17] = w18;
   assign tap[18] = w19;
   assign tap[19] = w20;
   assign tap[20] = w21;
   assign tap[21] = w22;
   assign tap[22] = w23;
   assign tap[23] = w24;
   assign tap[24] = w25;

   // Addresses 26..31 fall through both branches and are dropped.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 25; i++) kern[i] <= '0;
         bias <= '0;
      end else if (wt_we) begin
         if (wt_addr < 5'd25)
            kern[wt_addr] <= wt_data;
         else if (wt_addr == 5'd25)
            bias <= wt_data;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row <= '0;
         col <= '0;
      end else if (shift_in) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Qualify on the pre-increment coordinate; idle cycles inject a bubble.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_meta <= '0;
      end else begin
         q_meta.vld <= shift_in && (row >= EDGE) && (col >= EDGE);
         if (shift_in) begin
            q_meta.row  <= row - EDGE;
            q_meta.col  <= col - EDGE;
            q_meta.last <= (row == LAST_ROW) && (col == LAST_COL);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 25; i++) prod[i] <= '0;
         s1_meta <= '0;
      end else begin
         for (int i = 0; i < 25; i++) prod[i] <= P_W'(tap[i]) * P_W'(kern[i]);
         s1_meta <= q_meta;
      end
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         psum_c[r] = '0;
         for (int j = 0; j < 5; j++) psum_c[r] = psum_c[r] + PS_W'(prod[r*5+j]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < 5; r++) psum[r] <= '0;
         s2_meta <= '0;
      end else begin
         for (int r = 0; r < 5; r++) psum[r] <= psum_c[r];
         s2_meta <= s1_meta;
      end
   end

   always_comb begin
      total_c = ACC_W'(bias) <<< FRAC_BITS;
      for (int r = 0; r < 5; r++) total_c = total_c + ACC_W'(psum[r]);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         total   <= '0;
         s3_meta <= '0;
      end else begin
         total   <= total_c;
         s3_meta <= s2_meta;
      end
   end

   // Round half up, then saturate when the bits above the result sign disagree.
   always_comb begin
      rnd = total + RND;
      shd = rnd >>> FRAC_BITS;
      hi  = shd[ACC_W-1:DATA_WIDTH-1];
      if ((&hi) || !(|hi))
         sat = shd[DATA_WIDTH-1:0];
      else
         sat = {shd[ACC_W-1], {(DATA_WIDTH-1){~shd[ACC_W-1]}}};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         conv_out  <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= s3_meta.vld;
         out_last  <= s3_meta.vld & s3_meta.last;
         if (s3_meta.vld) begin
            conv_out <= sat;
            out_row  <= s3_meta.row;
            out_col  <= s3_meta.col;
         end
      end
   end

endmodule
